// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit sitting behind the execute stage.
//   - A taken jump becomes a registered one-cycle PC redirect plus a
//     FLUSH_CYCLES-long bubble injection into IF/ID and ID/EX.
//   - A hold request becomes a pipeline stall, with a sticky watchdog that
//     flags a hold lasting HOLD_MAX consecutive cycles.
//   - Two wrapping performance counters: accepted jumps and stalled cycles.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   jump_en_i, jump_addr_i    taken jump and its target from execute
//   hold_flag_i               execute requests a hold
//   perf_clr_i                synchronous clear of both perf counters
//   pc_redirect_o             PC loads pc_target_o this cycle (registered)
//   pc_target_o               registered redirect target, bit0 forced to 0
//   flush_o                   IF/ID and ID/EX load a bubble (registered)
//   stall_o                   PC, IF/ID and ID/EX hold (combinational)
//   hold_timeout_o            sticky hold watchdog flag
//   redirect_cnt_o            accepted jump count
//   stall_cnt_o               stalled cycle count
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int HOLD_MAX     = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             hold_flag_i,
  input  logic             perf_clr_i,
  output logic             pc_redirect_o,
  output logic [31:0]      pc_target_o,
  output logic             flush_o,
  output logic             stall_o,
  output logic             hold_timeout_o,
  output logic [CNT_W-1:0] redirect_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {RUN, REDIRECT, HOLD} state_t;

  localparam logic [2:0]  FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
  localparam logic [31:0] HOLD_LIM   = 32'(HOLD_MAX);
  localparam logic [31:0] HOLD_SAT   = 32'hFFFF_FFFF;

  state_t           state_q;
  logic [2:0]       flush_cnt_q;
  logic [31:0]      hold_cnt_q, hold_cnt_d;
  logic             pc_redirect_q, flush_q, timeout_q;
  logic [31:0]      pc_target_q;
  logic [CNT_W-1:0] redirect_cnt_q, stall_cnt_q;

  logic             stall_d;
  logic             accept_d;

  // Stall and jump acceptance. In RUN a simultaneous jump masks the hold:
  // the jump wins and the younger stages are flushed rather than frozen.
  // In REDIRECT both requests come from the wrong path and are ignored.
  always_comb begin
    stall_d    = 1'b0;
    accept_d   = 1'b0;
    hold_cnt_d = '0;
    unique case (state_q)
      RUN: begin
        accept_d = jump_en_i;
        stall_d  = hold_flag_i & ~jump_en_i;
        if (stall_d) hold_cnt_d = 32'd1;
      end
      HOLD: begin
        stall_d  = hold_flag_i;
        accept_d = ~hold_flag_i & jump_en_i;
        // Saturate so a very long hold never wraps back below HOLD_MAX.
        if (hold_flag_i)
          hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + 32'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      flush_cnt_q    <= '0;
      hold_cnt_q     <= '0;
      pc_redirect_q  <= 1'b0;
      flush_q        <= 1'b0;
      timeout_q      <= 1'b0;
      pc_target_q    <= '0;
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      pc_redirect_q <= 1'b0;
      hold_cnt_q    <= hold_cnt_d;

      if (HOLD_MAX != 0 && stall_d && hold_cnt_d == HOLD_LIM)
        timeout_q <= 1'b1;

      if (accept_d) begin
        state_q       <= REDIRECT;
        pc_target_q   <= jump_addr_i & ~32'h1;
        pc_redirect_q <= 1'b1;
        flush_q       <= 1'b1;
        flush_cnt_q   <= FLUSH_LAST;   // flush cycles remaining after the first
      end else begin
        unique case (state_q)
          RUN:  if (stall_d) state_q <= HOLD;
          HOLD: if (!hold_flag_i) state_q <= RUN;
          REDIRECT: begin
            if (flush_cnt_q == 3'd0) begin
              flush_q <= 1'b0;
              state_q <= RUN;
            end else begin
              flush_cnt_q <= flush_cnt_q - 3'd1;
            end
          end
          default: state_q <= RUN;
        endcase
      end

      // Clear takes priority over a same-edge increment.
      if (perf_clr_i) begin
        redirect_cnt_q <= '0;
        stall_cnt_q    <= '0;
      end else begin
        if (accept_d) redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
        if (stall_d)  stall_cnt_q    <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pc_redirect_o  = pc_redirect_q;
  assign pc_target_o    = pc_target_q;
  assign flush_o        = flush_q;
  assign stall_o        = stall_d;
  assign hold_timeout_o = timeout_q;
  assign redirect_cnt_o = redirect_cnt_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule
